// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//   Bus master for the memory controller port. On start it computes
//   C = A x B for 4x4 unsigned 8-bit matrices:
//     A rows   : DM1 (region 4'h0), one 32-bit word per row, byte k = A[i][k]
//     B elems  : DM2 (region 4'h1), one byte each, taken from Q[7:0]
//     C rows   : DM3 (region 4'h2), one 32-bit word per row, byte j = C[i][j]
//   Loop order is i (row) outer, j (column), k (inner). A single-cycle done
//   pulse follows the last C write.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high
//   start     in   1   request to begin, honoured in IDLE only
//   busy      out  1   high from RD_A of row 0 through WR_C of row 3
//   done      out  1   one-cycle pulse after the last C write
//   address   out  16  [15:12] region, [11:0] local offset (12-bit wrap)
//   DATA      out  32  C row during WR_C, otherwise 0
//   write_en  out  1   one cycle per C row
//   Q         in   32  read data, valid RD_LAT cycles after the address
//
// Configuration
//   MATMUL_SATURATE_EN : when defined, a result byte saturates to 8'hFF if
//                        the accumulator exceeds 255; otherwise it is the
//                        truncated low byte. Timing is identical.
// ---------------------------------------------------------------------------
module matmul_sequencer #(
  parameter logic [11:0] A_BASE = 12'h000,
  parameter logic [11:0] B_BASE = 12'h000,
  parameter logic [11:0] C_BASE = 12'h000,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] address,
  output logic [31:0] DATA,
  output logic        write_en,
  input  logic [31:0] Q
);

  localparam int unsigned WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_A   = 3'd1;
  localparam logic [2:0] S_WAIT_A = 3'd2;
  localparam logic [2:0] S_RD_B   = 3'd3;
  localparam logic [2:0] S_WAIT_B = 3'd4;
  localparam logic [2:0] S_WR_C   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]    state;
  logic [1:0]    row_i;
  logic [1:0]    col_j;
  logic [1:0]    inner_k;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   a_row;
  logic [17:0]   acc;
  logic [31:0]   c_row;

  logic [7:0]    a_elem;
  logic [15:0]   prod;
  logic [17:0]   acc_next;
  logic [7:0]    result;
  logic          wait_last;

  always_comb begin
    a_elem    = a_row[{inner_k, 3'b000} +: 8];
    prod      = a_elem * Q[7:0];
    acc_next  = acc + 18'(prod);
    wait_last = (wait_cnt == WAIT_LAST);
`ifdef MATMUL_SATURATE_EN
    result    = (acc_next > 18'd255) ? 8'hFF : acc_next[7:0];
`else
    result    = acc_next[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      row_i    <= '0;
      col_j    <= '0;
      inner_k  <= '0;
      wait_cnt <= '0;
      a_row    <= '0;
      acc      <= '0;
      c_row    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RD_A;
            row_i   <= '0;
            col_j   <= '0;
            inner_k <= '0;
            acc     <= '0;
          end
        end
        S_RD_A: begin
          wait_cnt <= '0;
          state    <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (wait_last) begin
            a_row <= Q;
            state <= S_RD_B;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_RD_B: begin
          wait_cnt <= '0;
          state    <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (wait_last) begin
            if (inner_k == 2'd3) begin
              // last product of the dot product goes straight into the byte
              c_row[{col_j, 3'b000} +: 8] <= result;
              acc     <= '0;
              inner_k <= '0;
              col_j   <= col_j + 2'd1;
              state   <= (col_j == 2'd3) ? S_WR_C : S_RD_B;
            end else begin
              acc     <= acc_next;
              inner_k <= inner_k + 2'd1;
              state   <= S_RD_B;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_WR_C: begin
          if (row_i == 2'd3) begin
            state <= S_DONE;
          end else begin
            row_i <= row_i + 2'd1;
            state <= S_RD_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state so a reset clears them on the following cycle.
  always_comb begin
    busy     = (state == S_RD_A) || (state == S_WAIT_A) || (state == S_RD_B) ||
               (state == S_WAIT_B) || (state == S_WR_C);
    done     = (state == S_DONE);
    write_en = (state == S_WR_C);
    DATA     = write_en ? c_row : '0;
    case (state)
      S_RD_A, S_WAIT_A: address = {4'h0, A_BASE + {10'b0, row_i}};
      S_RD_B, S_WAIT_B: address = {4'h1, B_BASE + {8'b0, inner_k, col_j}};
      S_WR_C:           address = {4'h2, C_BASE + {10'b0, row_i}};
      default:          address = '0;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] address;
  logic [31:0] DATA;
  logic        write_en;
  logic [31:0] Q;

  matmul_sequencer #(
    .A_BASE(12'h000),
    .B_BASE(12'h000),
    .C_BASE(12'hFFE),
    .RD_LAT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .address(address),
    .DATA(DATA),
    .write_en(write_en),
    .Q(Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: one-cycle read latency
  logic [31:0] dm1 [4096];
  logic [7:0]  dm2 [4096];

  always @(posedge clk) begin
    case (address[15:12])
      4'h0:    Q <= dm1[address[11:0]];
      4'h1:    Q <= {24'h0, dm2[address[11:0]]};
      default: Q <= 32'hDEADBEEF;
    endcase
  end

  // write / done monitor
  int          wr_cnt;
  int          done_cnt;
  logic [15:0] wr_addr [8];
  logic [31:0] wr_data [8];

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = address;
        wr_data[wr_cnt] = DATA;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  typedef struct {
    logic [3:0][31:0] a;
    logic [15:0][7:0] b;
    logic [3:0][31:0] c;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] exp_addr [4];
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    for (int n = 0; n < 4; n++) dm1[n] = vecs[v].a[n];
    for (int n = 0; n < 16; n++) dm2[n] = vecs[v].b[n];
  endtask

  task automatic run_vec(input int v, input bit repulse, input bit start_in_done, input string tag);
    int cyc;
    load(v);
    wr_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 5 || cyc == 60);
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), 32'd141);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (start_in_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " start_in_done_ignored"}, 32'(busy), 32'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " write_pulses"}, 32'(wr_cnt), 32'd4);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s row%0d data", tag, r), wr_data[r], vecs[v].c[r]);
      check($sformatf("%s row%0d addr", tag, r), 32'(wr_addr[r]), 32'(exp_addr[r]));
    end
  endtask

  initial begin
    int cyc;
    total = 0;
    bad   = 0;
    wr_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 4096; n++) begin
      dm1[n] = 32'h0;
      dm2[n] = 8'h0;
    end

    // C_BASE = 12'hFFE wraps inside the 12-bit local offset
    exp_addr[0] = 16'h2FFE;
    exp_addr[1] = 16'h2FFF;
    exp_addr[2] = 16'h2000;
    exp_addr[3] = 16'h2001;

    // 0: identity x B[k][j]=4k+j+1
    vecs[0].a = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    for (int n = 0; n < 16; n++) vecs[0].b[n] = 8'(n + 1);
    vecs[0].c = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    // 1: all ones x all ones
    vecs[1].a = {4{32'h01010101}};
    vecs[1].b = {16{8'h01}};
    vecs[1].c = {4{32'h04040404}};
    // 2: all FF x all FF (260100 = 0x3F804)
    vecs[2].a = {4{32'hFFFFFFFF}};
    vecs[2].b = {16{8'hFF}};
`ifdef MATMUL_SATURATE_EN
    vecs[2].c = {4{32'hFFFFFFFF}};
`else
    vecs[2].c = {4{32'h04040404}};
`endif
    // 3: 2*identity x B[k][j]=4k+j+1
    vecs[3].a = {32'h02000000, 32'h00020000, 32'h00000200, 32'h00000002};
    for (int n = 0; n < 16; n++) vecs[3].b[n] = 8'(n + 1);
    vecs[3].c = {32'h201E1C1A, 32'h18161412, 32'h100E0C0A, 32'h08060402};
    // 4: all ones x B[k][j]=4k+j+1 -> C[i][j] = 4j+28
    vecs[4].a = {4{32'h01010101}};
    for (int n = 0; n < 16; n++) vecs[4].b[n] = 8'(n + 1);
    vecs[4].c = {4{32'h2824201C}};

    // reset state
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ctrl", {12'h0, busy, done, write_en, 1'b0, address}, 32'h0);
    check("reset data", DATA, 32'h0);

    // reset and start together: reset wins
    start = 1'b1;
    @(negedge clk);
    check("reset_start busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_start idle", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(v, 1'b0, 1'b0, $sformatf("vec%0d", v));

    run_vec(1, 1'b1, 1'b0, "repulse");
    run_vec(0, 1'b0, 1'b1, "done_start");

    // reset in the cycle before row 2 WR_C (cycle 104)
    load(1);
    wr_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 104) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset ctrl", {12'h0, busy, done, write_en, 1'b0, address}, 32'h0);
    check("midreset data", DATA, 32'h0);
    repeat (200) @(negedge clk);
    check("midreset writes", 32'(wr_cnt), 32'd2);
    check("midreset done", 32'(done_cnt), 32'd0);
    run_vec(4, 1'b0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
